bank_reader: RTL and testbench

BANK_READER -- requirements
Module: bank_reader

---
 rtl/bank_reader.sv | 155 +++++++++++++++
 tb/tb_bank_reader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bank_reader: streams len 32-bit words from four byte-wide banks through a |
// | 2-entry output FIFO. Optional checksum: define BANK_READER_CHECKSUM_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bank_reader #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_rden,
   input  logic [7:0]        ram_q1,
   input  logic [7:0]        ram_q2,
   input  logic [7:0]        ram_q3,
   input  logic [7:0]        ram_q4,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [31:0]       checksum
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_reads_left;
   logic [ADDR_W:0]   r_words_left;
   logic              r_cap;
   logic              r_busy;
   logic              r_done;
   logic [31:0]       r_fifo [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;

   logic              w_pop;
   logic [2:0]        w_pending;
   logic              w_rden;

   assign out_valid = (r_count != 2'd0);
   assign w_pop     = out_valid & out_ready;
   // Entries the FIFO will hold once the word on the bank bus lands.
   assign w_pending = {1'b0, r_count} + {2'b00, r_cap} - {2'b00, w_pop};
   // Read strobe is decided from this cycle's pop so a full-rate stream never stalls.
   assign w_rden    = (r_state == ST_FETCH) && (w_pending < 3'd2);

   assign ram_rden  = w_rden;
   assign ram_addr  = r_addr;
   assign out_data  = out_valid ? r_fifo[r_rd_ptr] : 32'd0;
   assign busy      = r_busy;
   assign done      = r_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_reads_left <= '0;
         r_words_left <= '0;
         r_cap        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_cap  <= w_rden;
         if (w_pop) begin
            r_words_left <= r_words_left - (ADDR_W+1)'(1);
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state      <= ST_FETCH;
                     r_addr       <= base_addr;
                     r_reads_left <= len;
                     r_words_left <= len;
                     r_busy       <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               if (w_rden) begin
                  r_addr       <= r_addr + ADDR_W'(1);
                  r_reads_left <= r_reads_left - (ADDR_W+1)'(1);
                  if (r_reads_left == (ADDR_W+1)'(1)) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_pop && (r_words_left == (ADDR_W+1)'(1))) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            r_fifo[i] <= '0;
         end
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (r_cap) begin
            r_fifo[r_wr_ptr] <= {ram_q1, ram_q2, ram_q3, ram_q4};
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, r_cap} - {1'b0, w_pop};
      end
   end

`ifdef BANK_READER_CHECKSUM_EN
   logic [31:0] r_checksum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_checksum <= 32'd0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_checksum <= 32'd0;
      end else if (w_pop) begin
         r_checksum <= r_checksum + out_data;
      end
   end

   assign checksum = r_checksum;
`else
   assign checksum = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bank_reader.sv
`default_nettype none
// Scoreboard bench for bank_reader: directed jobs push expected words/addresses,
// a negedge monitor pops and compares whenever the DUT reads or transfers.
module tb_bank_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [13:0] base_addr;
   logic [14:0] len;
   logic [13:0] ram_addr;
   logic        ram_rden;
   logic [7:0]  ram_q1, ram_q2, ram_q3, ram_q4;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic [31:0] checksum;

   bank_reader #(.ADDR_W(14)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .len       (len),
      .ram_addr  (ram_addr),
      .ram_rden  (ram_rden),
      .ram_q1    (ram_q1),
      .ram_q2    (ram_q2),
      .ram_q3    (ram_q3),
      .ram_q4    (ram_q4),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Bank model: data appears the cycle after the read strobe.
   logic        use_tbl = 1'b0;
   logic [31:0] tbl [4];
   logic [31:0] bank_word = 32'd0;

   function automatic logic [31:0] word_of(input logic [13:0] a);
      logic [7:0] lo;
      lo = a[7:0];
      if (use_tbl) return tbl[a[1:0]];
      return {2'b00, a[13:8], lo, ~lo, lo + 8'h5A};
   endfunction

   always @(posedge clk) if (ram_rden) bank_word <= word_of(ram_addr);
   assign ram_q1 = bank_word[31:24];
   assign ram_q2 = bank_word[23:16];
   assign ram_q3 = bank_word[15:8];
   assign ram_q4 = bank_word[7:0];

   logic [31:0] exp_q [$];
   logic [13:0] addr_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Monitor state
   int          occ = 0;
   logic        rd_prev = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] held_data = 32'd0;
   logic        prev_done = 1'b0;
   int          rden_events = 0, valid_events = 0, words_seen = 0, done_events = 0;
   int          first_rden = -1, first_valid = -1, last_done = -1;

   always @(negedge clk) begin
      logic pop;
      logic [31:0] e;
      logic [13:0] ea;
      if (reset) begin
         occ = 0; rd_prev = 1'b0; hold_prev = 1'b0; prev_done = 1'b0;
      end else begin
         pop = out_valid && out_ready;
         check("valid_vs_model", {31'd0, out_valid}, {31'd0, occ > 0});
         if (ram_rden) begin
            rden_events++;
            if (first_rden < 0) first_rden = cyc;
            check("rden_room", {31'd0, (occ + int'(rd_prev) - int'(pop)) < 2}, 32'd1);
            if (addr_q.size() == 0) fail("rden_unexpected");
            else begin
               ea = addr_q.pop_front();
               check("ram_addr", {18'd0, ram_addr}, {18'd0, ea});
            end
         end
         if (out_valid) begin
            valid_events++;
            if (first_valid < 0) first_valid = cyc;
         end
         if (hold_prev) check("hold_stable", out_data, held_data);
         if (pop) begin
            words_seen++;
            if (exp_q.size() == 0) fail("word_unexpected");
            else begin
               e = exp_q.pop_front();
               check("out_data", out_data, e);
            end
         end
         if (done) begin
            done_events++;
            last_done = cyc;
            check("done_busy_low", {31'd0, busy}, 32'd0);
            if (prev_done) fail("done_width");
         end
         hold_prev = out_valid && !out_ready;
         held_data = out_data;
         prev_done = done;
         occ = occ + int'(rd_prev) - int'(pop);
         rd_prev = ram_rden;
      end
   end

   int t0;

   task automatic push_job(input logic [13:0] b, input int n);
      logic [13:0] a;
      for (int i = 0; i < n; i++) begin
         a = b + 14'(i);
         addr_q.push_back(a);
         exp_q.push_back(word_of(a));
      end
   endtask

   task automatic clear_stats();
      rden_events = 0; valid_events = 0;
      first_rden = -1; first_valid = -1; last_done = -1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the start-sampling edge.
   task automatic run_start(input logic [13:0] b, input logic [14:0] n);
      start = 1'b1; base_addr = b; len = n;
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0, n;
      d0 = done_events; n = 0;
      while (done_events == d0 && n < budget) begin
         @(posedge clk); n++;
      end
      #1;
      if (done_events == d0) fail("done_timeout");
   endtask

   task automatic check_drained(input string name);
      check({name, "_exp_left"}, exp_q.size(), 0);
      check({name, "_addr_left"}, addr_q.size(), 0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_rden"},  {31'd0, ram_rden}, 32'd0);
      check({name, "_addr"},  {18'd0, ram_addr}, 32'd0);
      check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
      check({name, "_data"},  out_data, 32'd0);
      check({name, "_busy"},  {31'd0, busy}, 32'd0);
      check({name, "_done"},  {31'd0, done}, 32'd0);
      check({name, "_cksum"}, checksum, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, d0, w0, v0;
      reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
      tbl[0] = 32'd0; tbl[1] = 32'd0; tbl[2] = 32'd0; tbl[3] = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1;

      // Job 1: base 0x0010, len 4, full-rate stream with hand-computed words
      clear_stats();
      addr_q.push_back(14'h0010); exp_q.push_back(32'h0010EF6A);
      addr_q.push_back(14'h0011); exp_q.push_back(32'h0011EE6B);
      addr_q.push_back(14'h0012); exp_q.push_back(32'h0012ED6C);
      addr_q.push_back(14'h0013); exp_q.push_back(32'h0013EC6D);
      run_start(14'h0010, 15'd4);
      check("t1_busy", {31'd0, busy}, 32'd1);
      wait_done(30);
      check("t1_first_rden", first_rden - t0 + 1, 1);
      check("t1_first_valid", first_valid - t0 + 1, 3);
      check("t1_done_cycle", last_done - t0 + 1, 7);
      check("t1_rden_count", rden_events, 4);
      check("t1_valid_cycles", valid_events, 4);
      check_drained("t1");

      // Job 2: address wrap at the top of the bank
      clear_stats();
      push_job(14'h3FFE, 4);
      run_start(14'h3FFE, 15'd4);
      wait_done(30);
      check("t2_rden_count", rden_events, 4);
      check_drained("t2");

      // Job 3: backpressure, plus a start pulse mid-job that must be ignored
      clear_stats();
      push_job(14'h0200, 8);
      run_start(14'h0200, 15'd8);
      d0 = done_events;
      for (int c = 0; c < 60 && done_events == d0; c++) begin
         out_ready = (c < 6) ? (c % 2 == 0) : (c < 11) ? 1'b0 : 1'b1;
         start     = (c == 2);
         base_addr = 14'h3000;
         len       = 15'd1;
         @(posedge clk); #1;
      end
      start = 1'b0; out_ready = 1'b1;
      if (done_events == d0) fail("t3_done_timeout");
      check("t3_rden_count", rden_events, 8);
      check_drained("t3");
      repeat (2) @(posedge clk); #1;
      check("t3_idle_busy", {31'd0, busy}, 32'd0);

      // Job 4: zero length
      clear_stats();
      d0 = done_events;
      run_start(14'h0055, 15'd0);
      check("t4_busy", {31'd0, busy}, 32'd0);
      wait_done(5);
      repeat (3) @(posedge clk); #1;
      check("t4_done_cycle", last_done - t0 + 1, 1);
      check("t4_done_count", done_events - d0, 1);
      check("t4_rden_count", rden_events, 0);
      check("t4_valid_cycles", valid_events, 0);

      // Job 5: reset mid-job, then a fresh job
      clear_stats();
      push_job(14'h0100, 10);
      w0 = words_seen;
      run_start(14'h0100, 15'd10);
      n = 0;
      while (words_seen < w0 + 3 && n < 50) begin
         @(negedge clk); n++;
      end
      if (words_seen < w0 + 3) fail("t5_words_timeout");
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_all_zero("t5_reset");
      exp_q.delete();
      addr_q.delete();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      d0 = done_events; v0 = valid_events; w0 = rden_events;
      repeat (4) @(posedge clk); #1;
      check("t5_no_stale_done", done_events, d0);
      check("t5_no_stale_valid", valid_events, v0);
      check("t5_no_stale_rden", rden_events, w0);
      push_job(14'h0000, 2);
      run_start(14'h0000, 15'd2);
      wait_done(20);
      check_drained("t5");

      // Job 6: checksum over fixed words
      use_tbl = 1'b1;
      tbl[0] = 32'h00000001; tbl[1] = 32'hFFFFFFFF; tbl[2] = 32'h00000005;
      push_job(14'h0000, 3);
      run_start(14'h0000, 15'd3);
      wait_done(20);
      check_drained("t6");
`ifdef BANK_READER_CHECKSUM_EN
      check("t6_checksum", checksum, 32'h00000005);
`else
      check("t6_checksum", checksum, 32'h00000000);
`endif
      use_tbl = 1'b0;

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
